// File: rtl/axis_pkt_arb2.sv
// Two-input, packet-granular round-robin AXI-Stream arbiter in front of the S2MM DMA slave port.
// A grant lasts from the first beat to the TLAST handshake; new grants need the S2MM channel running.
module axis_pkt_arb2 #(
  parameter int CNT_W = 16
) (
  input  logic             aclk,
  input  logic             areset,
  input  logic             s2mm_prmry_resetn,
  input  logic [31:0]      s0_tdata,
  input  logic [3:0]       s0_tkeep,
  input  logic             s0_tvalid,
  input  logic             s0_tlast,
  output logic             s0_tready,
  input  logic [31:0]      s1_tdata,
  input  logic [3:0]       s1_tkeep,
  input  logic             s1_tvalid,
  input  logic             s1_tlast,
  output logic             s1_tready,
  output logic [31:0]      m_tdata,
  output logic [3:0]       m_tkeep,
  output logic             m_tvalid,
  output logic             m_tlast,
  output logic             m_tdest,
  input  logic             m_tready,
  output logic             busy,
  output logic [CNT_W-1:0] pkt_cnt0,
  output logic [CNT_W-1:0] pkt_cnt1
);

  typedef enum logic [1:0] {IDLE = 2'd0, GNT0 = 2'd1, GNT1 = 2'd2} state_t;

  state_t           state_q;
  logic             last_gnt_q;
  logic             busy_q;
  logic [CNT_W-1:0] cnt0_q;
  logic [CNT_W-1:0] cnt1_q;

  logic req0, req1, eop0, eop1;

  assign req0 = s0_tvalid & s2mm_prmry_resetn;
  assign req1 = s1_tvalid & s2mm_prmry_resetn;
  assign eop0 = s0_tvalid & s0_tlast & m_tready;
  assign eop1 = s1_tvalid & s1_tlast & m_tready;

  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q    <= IDLE;
      last_gnt_q <= 1'b1;
      busy_q     <= 1'b0;
      cnt0_q     <= '0;
      cnt1_q     <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          // On a tie, source 0 wins only if source 1 held the previous grant.
          if (req0 && (!req1 || last_gnt_q)) begin
            state_q    <= GNT0;
            last_gnt_q <= 1'b0;
            busy_q     <= 1'b1;
          end else if (req1) begin
            state_q    <= GNT1;
            last_gnt_q <= 1'b1;
            busy_q     <= 1'b1;
          end
        end
        GNT0: begin
          if (eop0) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            cnt0_q  <= cnt0_q + CNT_W'(1);
          end
        end
        GNT1: begin
          if (eop1) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            cnt1_q  <= cnt1_q + CNT_W'(1);
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  // The datapath is a pure mux so the first beat appears in the cycle right after the grant edge.
  always_comb begin
    m_tdata   = '0;
    m_tkeep   = '0;
    m_tvalid  = 1'b0;
    m_tlast   = 1'b0;
    m_tdest   = last_gnt_q;
    s0_tready = 1'b0;
    s1_tready = 1'b0;
    case (state_q)
      GNT0: begin
        m_tdata   = s0_tdata;
        m_tkeep   = s0_tkeep;
        m_tvalid  = s0_tvalid;
        m_tlast   = s0_tlast;
        m_tdest   = 1'b0;
        s0_tready = m_tready;
      end
      GNT1: begin
        m_tdata   = s1_tdata;
        m_tkeep   = s1_tkeep;
        m_tvalid  = s1_tvalid;
        m_tlast   = s1_tlast;
        m_tdest   = 1'b1;
        s1_tready = m_tready;
      end
      default: ;
    endcase
  end

  assign busy     = busy_q;
  assign pkt_cnt0 = cnt0_q;
  assign pkt_cnt1 = cnt1_q;

endmodule

// File: tb/tb_axis_pkt_arb2.sv
// Bench for axis_pkt_arb2: a fixed cycle table, directed multi-cycle sequences, and random
// traffic, all checked against a packet-level reference model and a per-source beat scoreboard.
module tb_axis_pkt_arb2;
  localparam int CNT_W = 4;

  logic             aclk = 1'b0;
  logic             areset;
  logic             s2mm_prmry_resetn;
  logic [31:0]      s0_tdata, s1_tdata;
  logic [3:0]       s0_tkeep, s1_tkeep;
  logic             s0_tvalid, s1_tvalid, s0_tlast, s1_tlast;
  logic             s0_tready, s1_tready;
  logic [31:0]      m_tdata;
  logic [3:0]       m_tkeep;
  logic             m_tvalid, m_tlast, m_tdest, m_tready, busy;
  logic [CNT_W-1:0] pkt_cnt0, pkt_cnt1;

  axis_pkt_arb2 #(.CNT_W(CNT_W)) dut (
    .aclk(aclk), .areset(areset), .s2mm_prmry_resetn(s2mm_prmry_resetn),
    .s0_tdata(s0_tdata), .s0_tkeep(s0_tkeep), .s0_tvalid(s0_tvalid), .s0_tlast(s0_tlast),
    .s0_tready(s0_tready),
    .s1_tdata(s1_tdata), .s1_tkeep(s1_tkeep), .s1_tvalid(s1_tvalid), .s1_tlast(s1_tlast),
    .s1_tready(s1_tready),
    .m_tdata(m_tdata), .m_tkeep(m_tkeep), .m_tvalid(m_tvalid), .m_tlast(m_tlast),
    .m_tdest(m_tdest), .m_tready(m_tready), .busy(busy),
    .pkt_cnt0(pkt_cnt0), .pkt_cnt1(pkt_cnt1)
  );

  always #5 aclk = ~aclk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  bit chk_en  = 1'b1;
  bit sb_en   = 1'b0;

  // Reference model: owner of the output (-1 = nobody), last winner, packet counts.
  int mdl_own  = -1;
  int mdl_last = 1;
  int mdl_cnt [2];

  // Source generators and scoreboard.
  logic        src_v [2];
  logic [31:0] src_d [2];
  logic [3:0]  src_k [2];
  logic        src_l [2];
  int          bi [2], plen [2], fixlen [2];
  bit          en [2];
  int          pv;
  logic        hs [2];
  logic [36:0] q0 [$];
  logic [36:0] q1 [$];

  // Observed packets at the DMA side.
  int   pd [$], pl [$], pg [$];
  int   beats_cur, first_cyc, end_cyc;
  logic obs_mv, obs_busy;

  typedef struct {
    logic pr, v0, l0, v1, l1, rdy;
    logic mv, ml, md, bz, r0, r1;
    int   c0, c1;
  } vec_t;
  vec_t tbl [15];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_outputs();
    logic [31:0] ed;
    logic [3:0]  ek;
    logic        ev, el, edst, eb, er0, er1;
    ed = '0; ek = '0; ev = 1'b0; el = 1'b0; edst = 1'(mdl_last); eb = 1'b0; er0 = 1'b0; er1 = 1'b0;
    if (mdl_own == 0) begin
      ed = s0_tdata; ek = s0_tkeep; ev = s0_tvalid; el = s0_tlast; edst = 1'b0; eb = 1'b1;
      er0 = m_tready;
    end else if (mdl_own == 1) begin
      ed = s1_tdata; ek = s1_tkeep; ev = s1_tvalid; el = s1_tlast; edst = 1'b1; eb = 1'b1;
      er1 = m_tready;
    end
    chk("outputs", {m_tvalid, m_tlast, m_tdest, busy, s0_tready, s1_tready, m_tkeep, m_tdata},
        {ev, el, edst, eb, er0, er1, ek, ed});
    chk("pkt_cnt0", pkt_cnt0, mdl_cnt[0]);
    chk("pkt_cnt1", pkt_cnt1, mdl_cnt[1]);
  endtask

  task automatic model_update();
    bit v0, v1;
    if (areset) begin
      mdl_own = -1; mdl_last = 1; mdl_cnt[0] = 0; mdl_cnt[1] = 0;
    end else if (mdl_own < 0) begin
      v0 = s0_tvalid & s2mm_prmry_resetn;
      v1 = s1_tvalid & s2mm_prmry_resetn;
      if (v0 && v1)  mdl_own = 1 - mdl_last;
      else if (v0)   mdl_own = 0;
      else if (v1)   mdl_own = 1;
      if (mdl_own >= 0) mdl_last = mdl_own;
    end else if (m_tready && ((mdl_own == 0) ? (s0_tvalid && s0_tlast) : (s1_tvalid && s1_tlast))) begin
      mdl_cnt[mdl_own] = (mdl_cnt[mdl_own] + 1) % (1 << CNT_W);
      mdl_own = -1;
    end
  endtask

  // Called at the falling edge: record handshakes, score beats, advance the model, cross the edge.
  task automatic sample_and_advance();
    logic [36:0] e;
    int d;
    obs_mv   = m_tvalid;
    obs_busy = busy;
    hs[0] = s0_tvalid & s0_tready;
    hs[1] = s1_tvalid & s1_tready;
    if (m_tvalid && m_tready) begin
      d = int'(m_tdest);
      if (sb_en) begin
        if ((d == 0 && q0.size() == 0) || (d == 1 && q1.size() == 0)) begin
          n_tests++; n_fail++;
          $display("FAIL scoreboard: beat from src %0d with nothing pending (cycle %0d)", d, cyc);
        end else begin
          e = (d == 0) ? q0.pop_front() : q1.pop_front();
          chk("sb_beat", {m_tlast, m_tkeep, m_tdata}, e);
        end
      end
      if (beats_cur == 0) first_cyc = cyc;
      beats_cur++;
      if (m_tlast) begin
        pd.push_back(d); pl.push_back(beats_cur); pg.push_back(first_cyc - end_cyc - 1);
        $display("[TB] packet src=%0d beats=%0d cycle=%0d", d, beats_cur, cyc);
        end_cyc = cyc;
        beats_cur = 0;
      end
    end
    model_update();
    @(posedge aclk);
    #1;
    cyc++;
  endtask

  task automatic cycle_raw();
    #4;
    if (chk_en) check_outputs();
    sample_and_advance();
  endtask

  task automatic apply_src();
    s0_tvalid = src_v[0]; s0_tdata = src_d[0]; s0_tkeep = src_k[0]; s0_tlast = src_l[0];
    s1_tvalid = src_v[1]; s1_tdata = src_d[1]; s1_tkeep = src_k[1]; s1_tlast = src_l[1];
  endtask

  task automatic advance_src();
    for (int s = 0; s < 2; s++) begin
      if (hs[s]) begin
        src_v[s] = 1'b0;
        if (src_l[s]) bi[s] = 0; else bi[s]++;
      end
      if (!src_v[s] && en[s] && ($urandom_range(99) < pv)) begin
        if (bi[s] == 0) plen[s] = (fixlen[s] != 0) ? fixlen[s] : int'($urandom_range(1, 6));
        src_d[s] = $urandom;
        src_k[s] = 4'($urandom);
        src_l[s] = (bi[s] == plen[s] - 1);
        src_v[s] = 1'b1;
        if (s == 0) q0.push_back({src_l[s], src_k[s], src_d[s]});
        else        q1.push_back({src_l[s], src_k[s], src_d[s]});
      end
    end
  endtask

  task automatic step();
    apply_src();
    cycle_raw();
    advance_src();
  endtask

  task automatic clear_tb();
    for (int s = 0; s < 2; s++) begin
      src_v[s] = 1'b0; src_d[s] = '0; src_k[s] = '0; src_l[s] = 1'b0;
      bi[s] = 0; plen[s] = 1; en[s] = 1'b0; fixlen[s] = 0; hs[s] = 1'b0;
    end
    q0.delete(); q1.delete(); pd.delete(); pl.delete(); pg.delete();
    beats_cur = 0; first_cyc = cyc; end_cyc = cyc;
  endtask

  task automatic do_reset();
    clear_tb();
    apply_src();
    areset = 1'b1;
    #4;
    sample_and_advance();
    areset = 1'b0;
    clear_tb();
  endtask

  initial begin
    areset = 1'b0; s2mm_prmry_resetn = 1'b0; m_tready = 1'b0; pv = 100;
    clear_tb();
    apply_src();

    // ---------------- cycle table from reset ----------------
    tbl[0]  = '{1,1,0,1,0,1, 0,0,1,0,0,0, 0,0};
    tbl[1]  = '{1,1,1,1,0,1, 1,1,0,1,1,0, 0,0};
    tbl[2]  = '{1,1,0,1,1,1, 0,0,0,0,0,0, 1,0};
    tbl[3]  = '{1,1,0,1,1,0, 1,1,1,1,0,0, 1,0};
    tbl[4]  = '{1,1,0,1,1,1, 1,1,1,1,0,1, 1,0};
    tbl[5]  = '{0,1,0,1,0,1, 0,0,1,0,0,0, 1,1};
    tbl[6]  = '{0,1,0,1,0,1, 0,0,1,0,0,0, 1,1};
    tbl[7]  = '{1,1,1,0,0,1, 0,0,1,0,0,0, 1,1};
    tbl[8]  = '{0,1,1,0,0,1, 1,1,0,1,1,0, 1,1};
    tbl[9]  = '{0,1,0,1,0,1, 0,0,0,0,0,0, 2,1};
    tbl[10] = '{1,0,0,0,0,1, 0,0,0,0,0,0, 2,1};
    tbl[11] = '{1,0,0,1,0,1, 0,0,0,0,0,0, 2,1};
    tbl[12] = '{1,0,0,0,0,1, 0,0,1,1,0,1, 2,1};
    tbl[13] = '{1,0,0,1,1,1, 1,1,1,1,0,1, 2,1};
    tbl[14] = '{1,0,0,0,0,1, 0,0,1,0,0,0, 2,2};

    do_reset();
    sb_en = 1'b0;
    for (int i = 0; i < 15; i++) begin
      s2mm_prmry_resetn = tbl[i].pr; m_tready = tbl[i].rdy;
      s0_tvalid = tbl[i].v0; s0_tlast = tbl[i].l0; s0_tdata = 32'hA0A0_0000 + i; s0_tkeep = 4'h5;
      s1_tvalid = tbl[i].v1; s1_tlast = tbl[i].l1; s1_tdata = 32'hB0B0_0000 + i; s1_tkeep = 4'hA;
      #4;
      chk($sformatf("table_row%0d", i),
          {m_tvalid, m_tlast, m_tdest, busy, s0_tready, s1_tready, pkt_cnt0, pkt_cnt1},
          {tbl[i].mv, tbl[i].ml, tbl[i].md, tbl[i].bz, tbl[i].r0, tbl[i].r1,
           4'(tbl[i].c0), 4'(tbl[i].c1)});
      check_outputs();
      sample_and_advance();
    end

    // ---------------- single source, 16-beat packets ----------------
    sb_en = 1'b1;
    do_reset();
    s2mm_prmry_resetn = 1'b1; m_tready = 1'b1; pv = 100;
    en[0] = 1'b1; fixlen[0] = 16;
    for (int k = 0; k < 300 && pd.size() < 3; k++) step();
    chk("single_pkts", pd.size(), 3);
    for (int i = 0; i < pd.size(); i++) begin
      chk("single_dest", pd[i], 0);
      chk("single_len", pl[i], 16);
      if (i > 0) chk("single_gap", pg[i], 1);
    end
    chk("single_cnt0", pkt_cnt0, 3);

    // ---------------- contention, 4-beat packets ----------------
    do_reset();
    s2mm_prmry_resetn = 1'b1; m_tready = 1'b1;
    en[0] = 1'b1; en[1] = 1'b1; fixlen[0] = 4; fixlen[1] = 4;
    for (int k = 0; k < 300 && pd.size() < 6; k++) step();
    chk("cont_pkts", pd.size(), 6);
    for (int i = 0; i < pd.size(); i++) begin
      chk("cont_order", pd[i], i % 2);
      chk("cont_len", pl[i], 4);
      if (i > 0) chk("cont_gap", pg[i], 1);
    end
    chk("cont_cnt_eq", pkt_cnt0, pkt_cnt1);
    chk("cont_cnt0", pkt_cnt0, 3);

    // ---------------- status gating ----------------
    do_reset();
    s2mm_prmry_resetn = 1'b0; m_tready = 1'b1;
    en[0] = 1'b1; en[1] = 1'b1; fixlen[0] = 8; fixlen[1] = 8;
    for (int k = 0; k < 6; k++) begin
      step();
      chk("gate_off_mv", obs_mv, 1'b0);
    end
    s2mm_prmry_resetn = 1'b1;
    for (int k = 0; k < 50 && beats_cur < 3; k++) step();
    s2mm_prmry_resetn = 1'b0;
    for (int k = 0; k < 50 && pd.size() < 1; k++) step();
    chk("gate_pkts", pd.size(), 1);
    if (pd.size() >= 1) begin
      chk("gate_len", pl[0], 8);
      chk("gate_dest", pd[0], 0);
    end
    for (int k = 0; k < 6; k++) begin
      step();
      chk("gate_hold_mv", obs_mv, 1'b0);
      chk("gate_hold_busy", obs_busy, 1'b0);
    end
    s2mm_prmry_resetn = 1'b1;
    for (int k = 0; k < 50 && pd.size() < 2; k++) step();
    chk("gate_resume_pkts", pd.size(), 2);
    if (pd.size() >= 2) chk("gate_resume_dest", pd[1], 1);

    // ---------------- reset mid-packet ----------------
    do_reset();
    s2mm_prmry_resetn = 1'b1; m_tready = 1'b1;
    en[0] = 1'b1; fixlen[0] = 8;
    for (int k = 0; k < 100 && !(pd.size() == 2 && beats_cur == 4); k++) step();
    chk("rstmid_cnt0_before", pkt_cnt0, 2);
    areset = 1'b1;
    step();
    areset = 1'b0;
    clear_tb();
    step();
    chk("rstmid_busy", obs_busy, 1'b0);
    chk("rstmid_mv", obs_mv, 1'b0);
    chk("rstmid_cnt0", pkt_cnt0, 0);
    en[0] = 1'b1; en[1] = 1'b1; fixlen[0] = 2; fixlen[1] = 2;
    for (int k = 0; k < 50 && pd.size() < 1; k++) step();
    chk("rstmid_pkts", pd.size(), 1);
    if (pd.size() >= 1) chk("rstmid_winner", pd[0], 0);

    // ---------------- counter wrap ----------------
    do_reset();
    s2mm_prmry_resetn = 1'b1; m_tready = 1'b1;
    en[1] = 1'b1; fixlen[1] = 1;
    for (int k = 0; k < 200 && pd.size() < 17; k++) step();
    chk("wrap_pkts", pd.size(), 17);
    for (int i = 1; i < pd.size(); i++) begin
      chk("wrap_len", pl[i], 1);
      chk("wrap_gap", pg[i], 1);
    end
    chk("wrap_cnt1", pkt_cnt1, 1);
    chk("wrap_cnt0", pkt_cnt0, 0);

    // ---------------- random traffic with backpressure ----------------
    do_reset();
    en[0] = 1'b1; en[1] = 1'b1; fixlen[0] = 0; fixlen[1] = 0; pv = 70;
    for (int k = 0; k < 3000; k++) begin
      m_tready = ($urandom_range(99) < 60);
      s2mm_prmry_resetn = ($urandom_range(19) != 0);
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
